// File: rtl/serial_reg_loader_pkg.sv
// Shared types and helpers for the serial register loader.
// Optional parity stage is enabled by defining SERIAL_REG_LOADER_PARITY_EN.
package serial_reg_loader_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE     = 3'd0,
    S_ADDR     = 3'd1,
    S_DATA     = 3'd2,
    S_PARITY   = 3'd3,
    S_COMMIT   = 3'd4,
    S_WAIT_END = 3'd5
  } state_e;

  // Bit counter width: enough to hold max(addr_w, data_w) itself.
  function automatic int unsigned cnt_width(input int unsigned addr_w, input int unsigned data_w);
    int unsigned m;
    m = (addr_w > data_w) ? addr_w : data_w;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/serial_reg_loader_shift_in.sv
// MSB-first shift register with an accepted-bit counter and full flag.
module sr_shift_in #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [WIDTH-1:0] data,
  output logic             full
);

  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign full = (cnt_q == CNT_W'(WIDTH));
  assign data = data_q;

  // Shift in one bit per enable until WIDTH bits are held; clr restarts the count.
  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (shift_en && !full) begin
      data_d = {data_q[WIDTH-2:0], bit_in};
      cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  // Register state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_reg_loader.sv
// Deserialises a framed bit stream (address then data, MSB first) into a
// one-cycle one-hot write enable and a data word for the register bank.
// Define SERIAL_REG_LOADER_PARITY_EN to append an even-parity bit to each frame.
module serial_reg_loader #(
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned NUM_REGS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame,
  input  logic                bit_valid,
  input  logic                bit_in,
  output logic [NUM_REGS-1:0] reg_we,
  output logic [DATA_W-1:0]   reg_d,
  output logic                busy,
  output logic                done,
  output logic                err
);
  import serial_reg_loader_pkg::*;

  localparam int unsigned CNT_W = cnt_width(ADDR_W, DATA_W);
  localparam logic [ADDR_W:0] NUM_REGS_L = (ADDR_W+1)'(NUM_REGS);

  state_e              state_q, state_d;
  logic [NUM_REGS-1:0] reg_we_q, reg_we_d;
  logic [DATA_W-1:0]   reg_d_q, reg_d_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                addr_shift, data_shift, cnt_clr;
  logic [ADDR_W-1:0]   addr_val;
  logic [DATA_W-1:0]   data_val;
  logic                addr_full, data_full;
  logic                write_ok;

`ifdef SERIAL_REG_LOADER_PARITY_EN
  logic par_q, par_d;
  logic par_full_q, par_full_d;
`endif

  sr_shift_in #(.WIDTH(ADDR_W), .CNT_W(CNT_W)) u_addr (
    .clk(clk), .rst(rst), .clr(cnt_clr), .shift_en(addr_shift),
    .bit_in(bit_in), .data(addr_val), .full(addr_full)
  );

  sr_shift_in #(.WIDTH(DATA_W), .CNT_W(CNT_W)) u_data (
    .clk(clk), .rst(rst), .clr(cnt_clr), .shift_en(data_shift),
    .bit_in(bit_in), .data(data_val), .full(data_full)
  );

`ifdef SERIAL_REG_LOADER_PARITY_EN
  assign write_ok = ({1'b0, addr_val} < NUM_REGS_L) && !(^{addr_val, data_val, par_q});
`else
  assign write_ok = ({1'b0, addr_val} < NUM_REGS_L);
`endif

  // Next state and registered outputs. The first bit of each field may
  // arrive in the same cycle its state is entered, so the previous state
  // routes it into the next field's shifter.
  always_comb begin
    state_d    = state_q;
    reg_we_d   = '0;
    reg_d_d    = reg_d_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    addr_shift = 1'b0;
    data_shift = 1'b0;
`ifdef SERIAL_REG_LOADER_PARITY_EN
    par_d      = par_q;
    par_full_d = par_full_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (frame) begin
          state_d    = S_ADDR;
          addr_shift = bit_valid;
        end
      end
      S_ADDR: begin
        if (!frame) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else if (addr_full) begin
          state_d    = S_DATA;
          data_shift = bit_valid;
        end else begin
          addr_shift = bit_valid;
        end
      end
      S_DATA: begin
`ifdef SERIAL_REG_LOADER_PARITY_EN
        if (!frame) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else if (data_full) begin
          state_d = S_PARITY;
          if (bit_valid) begin
            par_d      = bit_in;
            par_full_d = 1'b1;
          end
        end else begin
          data_shift = bit_valid;
        end
`else
        // A complete frame commits even if frame falls right after the last bit.
        if (data_full) begin
          state_d = S_COMMIT;
        end else if (!frame) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          data_shift = bit_valid;
        end
`endif
      end
`ifdef SERIAL_REG_LOADER_PARITY_EN
      S_PARITY: begin
        if (par_full_q) begin
          state_d    = S_COMMIT;
          par_full_d = 1'b0;
        end else if (!frame) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else if (bit_valid) begin
          par_d      = bit_in;
          par_full_d = 1'b1;
        end
      end
`endif
      S_COMMIT: begin
        state_d = S_WAIT_END;
        if (write_ok) begin
          for (int unsigned i = 0; i < NUM_REGS; i++) begin
            reg_we_d[i] = (addr_val == ADDR_W'(i));
          end
          reg_d_d = data_val;
          done_d  = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      S_WAIT_END: begin
        if (!frame) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    cnt_clr = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      reg_we_q <= '0;
      reg_d_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef SERIAL_REG_LOADER_PARITY_EN
      par_q      <= 1'b0;
      par_full_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      reg_we_q <= reg_we_d;
      reg_d_q  <= reg_d_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
`ifdef SERIAL_REG_LOADER_PARITY_EN
      par_q      <= par_d;
      par_full_q <= par_full_d;
`endif
    end
  end

  assign reg_we = reg_we_q;
  assign reg_d  = reg_d_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: tb/tb_serial_reg_loader.sv
// Self-checking bench for serial_reg_loader (NUM_REGS=12).
// Honours SERIAL_REG_LOADER_PARITY_EN for the frame format.
`timescale 1ns/1ps
module tb_serial_reg_loader;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned NREGS  = 12;
`ifdef SERIAL_REG_LOADER_PARITY_EN
  localparam int unsigned FRAME_BITS = ADDR_W + DATA_W + 1;
`else
  localparam int unsigned FRAME_BITS = ADDR_W + DATA_W;
`endif
  localparam int unsigned LAT = 2;

  logic clk = 1'b0;
  logic rst, frame, bit_valid, bit_in;
  logic [NREGS-1:0]  reg_we;
  logic [DATA_W-1:0] reg_d;
  logic busy, done, err;

  serial_reg_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NREGS)) dut (
    .clk(clk), .rst(rst), .frame(frame), .bit_valid(bit_valid), .bit_in(bit_in),
    .reg_we(reg_we), .reg_d(reg_d), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int unsigned n_pass = 0, n_fail = 0, n_total = 0, cyc = 0, fid = 0;
  int unsigned we_cnt, we_cyc, done_cnt, err_cnt;
  logic [NREGS-1:0]  we_val;
  logic [DATA_W-1:0] prev_d, model_d;
  logic stream[$];
  int unsigned cur_addr, cur_data;
  bit cur_par_ok;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s (frame %0d): observed %0h, expected %0h", tag, fid, obs, exp);
    end
  endtask

  task automatic clear_stats();
    we_cnt = 0; we_cyc = 0; done_cnt = 0; err_cnt = 0; we_val = '0;
  endtask

  // Drive one clock cycle of inputs, then observe the results at the falling edge.
  task automatic cycle(input logic f, input logic v, input logic b);
    frame = f; bit_valid = v; bit_in = b;
    @(negedge clk);
    cyc++;
    if (reg_we != '0) begin we_cnt++; we_val = reg_we; we_cyc = cyc; end
    if (done) done_cnt++;
    if (err)  err_cnt++;
    if (!rst) begin
      check("we_onehot0", 32'($onehot0(reg_we)), 32'd1);
      if (reg_we == '0) check("reg_d_hold", 32'(reg_d), 32'(prev_d));
    end
    prev_d = reg_d;
  endtask

  // Build the serial stream: address MSB first, data MSB first, optional parity, extra bits.
  task automatic build(input int unsigned addr, input int unsigned data, input bit bad_par,
                       input int unsigned extra);
    int unsigned ones;
    logic b;
    ones = 0;
    stream.delete();
    cur_addr = addr; cur_data = data;
    for (int i = ADDR_W - 1; i >= 0; i--) begin
      b = 1'((addr >> i) & 32'd1); ones += 32'(b); stream.push_back(b);
    end
    for (int i = DATA_W - 1; i >= 0; i--) begin
      b = 1'((data >> i) & 32'd1); ones += 32'(b); stream.push_back(b);
    end
`ifdef SERIAL_REG_LOADER_PARITY_EN
    stream.push_back(1'(ones % 2) ^ bad_par);
    cur_par_ok = !bad_par;
`else
    cur_par_ok = 1'b1;
`endif
    for (int unsigned i = 0; i < extra; i++) stream.push_back(1'($urandom));
  endtask

  // Send nsend bits of the stream (a strobe every gap cycles), hold frame for
  // tail cycles with random strobes, drop frame, then compare with the model.
  task automatic send_frame(input int unsigned nsend, input int unsigned gap, input int unsigned tail);
    int unsigned last_cyc;
    bit wr;
    last_cyc = 0;
    fid++;
    clear_stats();
    for (int unsigned i = 0; i < nsend; i++) begin
      for (int unsigned g = 1; g < gap; g++) cycle(1'b1, 1'b0, 1'($urandom));
      cycle(1'b1, 1'b1, stream[i]);
      if (i == FRAME_BITS - 1) last_cyc = cyc;
    end
    for (int unsigned t = 0; t < tail; t++) cycle(1'b1, 1'($urandom), 1'($urandom));
    for (int unsigned t = 0; t < 3; t++) cycle(1'b0, 1'($urandom), 1'($urandom));
    wr = (nsend >= FRAME_BITS) && (cur_addr < NREGS) && cur_par_ok;
    check("we_count", we_cnt, 32'(wr));
    check("done_count", done_cnt, 32'(wr));
    check("err_count", err_cnt, 32'(!wr));
    if (wr) begin
      model_d = DATA_W'(cur_data);
      check("we_value", 32'(we_val), 32'd1 << cur_addr);
      check("we_latency", we_cyc - last_cyc, LAT);
    end
    check("reg_d", 32'(reg_d), 32'(model_d));
    check("busy_end", 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; frame = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    model_d = '0; prev_d = '0;
    clear_stats();
    @(negedge clk);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1);
    check("rst_we", 32'(reg_we), 32'd0);
    check("rst_d", 32'(reg_d), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b0);
    check("idle_strobe_busy", 32'(busy), 32'd0);

    // Basic write, then the same frame with a strobe every third cycle.
    build(3, 32'hA5, 1'b0, 0);  send_frame(FRAME_BITS, 1, 4);
    build(3, 32'hA5, 1'b0, 0);  send_frame(FRAME_BITS, 3, 4);
    // Illegal address: reg_d keeps A5.
    build(13, 32'hFF, 1'b0, 0); send_frame(FRAME_BITS, 1, 4);
    // Abort after 4 address + 3 data bits, then a good frame.
    build(5, 32'h77, 1'b0, 0);  send_frame(7, 1, 0);
    build(0, 32'h3C, 1'b0, 0);  send_frame(FRAME_BITS, 2, 4);
    // Address boundaries; frame drops right after the final bit.
    build(11, $urandom_range(0, 255), 1'b0, 0); send_frame(FRAME_BITS, 1, 0);
    build(12, $urandom_range(0, 255), 1'b0, 0); send_frame(FRAME_BITS, 1, 4);
    build(15, $urandom_range(0, 255), 1'b0, 0); send_frame(FRAME_BITS, 2, 2);
    // Abort with only the address complete.
    build(2, 32'h11, 1'b0, 0);  send_frame(ADDR_W, 1, 0);

    // Reset mid-frame after 6 bits: discarded, no err, outputs cleared.
    build(7, 32'h5A, 1'b0, 0);
    fid++;
    clear_stats();
    for (int unsigned i = 0; i < 6; i++) cycle(1'b1, 1'b1, stream[i]);
    rst = 1'b1;
    cycle(1'b0, 1'b0, 1'b0);
    check("midrst_we", 32'(reg_we), 32'd0);
    check("midrst_d", 32'(reg_d), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    check("midrst_err_count", err_cnt, 32'd0);
    check("midrst_we_count", we_cnt, 32'd0);
    rst = 1'b0;
    model_d = '0;
    cycle(1'b0, 1'b0, 1'b0);
    // Frame with 3 trailing bits: only the first frame's worth counts.
    build(9, 32'hC3, 1'b0, 3);  send_frame(FRAME_BITS + 3, 1, 3);

`ifdef SERIAL_REG_LOADER_PARITY_EN
    build(2, 32'h01, 1'b0, 0);  send_frame(FRAME_BITS, 1, 4);
    build(2, 32'h01, 1'b1, 0);  send_frame(FRAME_BITS, 1, 4);
    build(4, 32'h80, 1'b0, 0);  send_frame(FRAME_BITS - 1, 1, 0);
`endif

    // Randomized frames: random address/data/gap, occasional abort or bad parity.
    for (int unsigned k = 0; k < 24; k++) begin
      build($urandom_range(0, 15), $urandom_range(0, 255), ($urandom_range(0, 3) == 0), 2);
      if ($urandom_range(0, 4) == 0)
        send_frame($urandom_range(1, FRAME_BITS - 1), $urandom_range(1, 3), 0);
      else
        send_frame(FRAME_BITS + $urandom_range(0, 2), $urandom_range(1, 3), $urandom_range(0, 4));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
